speck_decrypt_core: RTL and testbench
=====================================

# speck_decrypt_core

Iterative SPECK128/128 decryption engine: the inverse of the `round_encrypt`/`key_schedule` encryption chain. It accepts a 128-bit ciphertext and master key and expands all round keys into an internal round-key store. It then applies the inverse round function in reverse key order and returns the plaintext with a one-cycle `finished` pulse. It sits beside the encryption chain and uses the same `signal_start`/`finished`/`state_response` handshake.

## Interface
- `NR_ROUNDS`, 32, number of rounds; must match the encryption side.
- `WORD`, 64, word width; the block is 2×WORD wide.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `signal_start`  in  1  start request; sampled only in IDLE.
- `key`  in  128  master key; `[127:64]` = k0 (round key 0), `[63:0]` = l0.
- `ciphertext`  in  128  `[127:64]` = x, `[63:0]` = y.
- `plaintext`  out  128  result, same packing; held until the next start.
- `finished`  out  1  one-cycle pulse; `plaintext` is valid from this cycle.
- `state_response`  out  4  current state code.

## Operation
- **Round function:** rotations α=8, β=3; all additions and subtractions are mod 2^64.
- **Key step i:** l' = (k + ROR(l,8)) ^ i, then k' = ROL(k,3) ^ l'. The 64-bit index i is zero-extended.
- **Inverse round with rk:** y' = ROR(x ^ y, 3), then x' = ROL((x ^ rk) − y', 8).
- **IDLE (code 0):**
  - If `signal_start`=1: latch `ciphertext` into x/y, latch `key` into k/l, set ctr=0, go to EXPAND.
  - Otherwise stay.
- **EXPAND (code 1):**
  - Each cycle: rk[ctr] ← k, apply key step with i=ctr, ctr+1.
  - After rk[NR_ROUNDS−1] is written: set ctr=NR_ROUNDS−1, go to DECRYPT.
- **DECRYPT (code 2):**
  - Each cycle: apply the inverse round with rk[ctr], then ctr−1.
  - After ctr=0 is processed: go to DONE. ctr never wraps below 0.
- **DONE (code 3):** `plaintext` ← {x,y}, `finished`=1 for this one cycle, go to IDLE.
- **Busy handling:** `signal_start` outside IDLE is ignored, not queued. Input changes after the start cycle have no effect.
- **Back-to-back:** if `signal_start` is held high, a new operation starts in the cycle after DONE.
- **Reset values:** `plaintext`=0, `finished`=0, `state_response`=0, ctr=0, state IDLE, key cache invalid.
- **Reset mid-operation:** aborts immediately, with no `finished` pulse.
- rk contents need no reset.

## Timing
- Start sampled at edge E0. EXPAND occupies E1–E32. DECRYPT occupies E33–E64.
- `finished` is high in the cycle after E65: full latency is 65 cycles start-to-finished (NR_ROUNDS=32).
- General latency: 2·NR_ROUNDS+1 cycles.
- Throughput: one block per 2·NR_ROUNDS+2 cycles with `signal_start` held high.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **`SPECK_KEY_CACHE_EN` defined:**
  - The block stores the last fully expanded key and a cache-valid flag.
  - On start with `key` equal to the stored key and the flag valid: go directly IDLE → DECRYPT, latency NR_ROUNDS+1 (33).
  - The flag is set when EXPAND completes. It is cleared by `rst`, including a reset during EXPAND.
- **Not defined:** every operation runs EXPAND, and latency is always 65.

## Structure
- `cipher_settings.vh` holds:
  - `NR_ROUNDS`, word width, and α/β rotation constants.
  - The four state codes (IDLE=0, EXPAND=1, DECRYPT=2, DONE=3).
- Sub-module `round_decrypt`: purely combinational inverse round, ports x, y, rk in; x', y' out.
  - Mirrors `round_encrypt` and is reusable by a future unrolled decrypt chain.
- The key step is inline in this block; it duplicates `key_schedule` arithmetic, so the constants must come from the shared header.

## Test plan
- **Official vector:** key={0706050403020100, 0f0e0d0c0b0a0908}, ciphertext={a65d985179783265, 7860fedf5c570d18}, start pulse → `finished` 65 cycles later, plaintext={6c61766975716520, 7469206564616d20}.
- **Round trip:** encrypt random 128-bit plaintext/key with the 32-stage `round_encrypt`/`key_schedule` chain, feed the result here → original plaintext returned, for ≥100 vectors.
- **Start while busy:**
  - Pulse `signal_start` during EXPAND and during DECRYPT → ignored; exactly one `finished`, correct result.
  - Hold start high → consecutive `finished` pulses 66 cycles apart.
- **Reset mid-DECRYPT:** assert `rst` at cycle 40 → next cycle state_response=0, plaintext=0, finished=0; a following official-vector run still gives the correct result in 65 cycles.
- **Input change after start:** change `ciphertext` and `key` at cycle 1 → output matches the values latched at start.
- **With `SPECK_KEY_CACHE_EN`:**
  - Second run with the same key → `finished` after 33 cycles, correct plaintext.
  - Different key → 65 cycles.
  - `rst` between runs → 65 cycles.

Source files
------------

// File: rtl/speck_decrypt_core_pkg.sv
// Shared SPECK128/128 cipher settings: round count, word width, rotation
// constants, state codes and rotate helpers used by the decrypt datapath.
package speck_decrypt_core_pkg;

  localparam int NR_ROUNDS = 32;
  localparam int WORD      = 64;
  localparam int ALPHA     = 8;
  localparam int BETA      = 3;
  localparam int CTR_W     = $clog2(NR_ROUNDS);

  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(NR_ROUNDS - 1);

  typedef logic [WORD-1:0] word_t;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_EXPAND  = 4'd1,
    ST_DECRYPT = 4'd2,
    ST_DONE    = 4'd3
  } state_e;

  function automatic word_t rol(input word_t v, input int unsigned n);
    return (v << n) | (v >> (WORD - n));
  endfunction

  function automatic word_t ror(input word_t v, input int unsigned n);
    return (v >> n) | (v << (WORD - n));
  endfunction

endpackage

// File: rtl/speck_decrypt_core_round_decrypt.sv
// Purely combinational SPECK inverse round; the mirror of round_encrypt,
// usable on its own in an unrolled decrypt chain.
module round_decrypt
  import speck_decrypt_core_pkg::*;
(
  input  word_t x,
  input  word_t y,
  input  word_t rk,
  output word_t x_nxt,
  output word_t y_nxt
);

  assign y_nxt = ror(x ^ y, BETA);
  assign x_nxt = rol((x ^ rk) - y_nxt, ALPHA);

endmodule

// File: rtl/speck_decrypt_core.sv
// Iterative SPECK128/128 decryption engine: expands round keys, then runs the
// inverse rounds in reverse key order. Optional macro SPECK_KEY_CACHE_EN skips
// expansion when the master key matches the last fully expanded key.
module speck_decrypt_core
  import speck_decrypt_core_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              signal_start,
  input  logic [2*WORD-1:0] key,
  input  logic [2*WORD-1:0] ciphertext,
  output logic [2*WORD-1:0] plaintext,
  output logic              finished,
  output logic [3:0]        state_response
);

  state_e            state_q, state_d;
  logic [CTR_W-1:0]  ctr_q, ctr_d;
  word_t             x_q, x_d, y_q, y_d;
  word_t             k_q, k_d, l_q, l_d;
  logic [2*WORD-1:0] pt_q, pt_d;
  logic              fin_q, fin_d;
  word_t             rk_q [NR_ROUNDS];
  logic              rk_we;
  word_t             l_step, k_step;
  word_t             x_inv, y_inv;
  logic              cache_hit;

`ifdef SPECK_KEY_CACHE_EN
  logic [2*WORD-1:0] ckey_q, ckey_d;
  logic              cvld_q, cvld_d;

  assign cache_hit = cvld_q && (key == ckey_q);
`else
  assign cache_hit = 1'b0;
`endif

  // Key step duplicates key_schedule arithmetic; constants come from the package.
  assign l_step = (k_q + ror(l_q, ALPHA)) ^ word_t'(ctr_q);
  assign k_step = rol(k_q, BETA) ^ l_step;

  round_decrypt u_round (
    .x     (x_q),
    .y     (y_q),
    .rk    (rk_q[ctr_q]),
    .x_nxt (x_inv),
    .y_nxt (y_inv)
  );

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    x_d     = x_q;
    y_d     = y_q;
    k_d     = k_q;
    l_d     = l_q;
    pt_d    = pt_q;
    fin_d   = 1'b0;
    rk_we   = 1'b0;
`ifdef SPECK_KEY_CACHE_EN
    ckey_d  = ckey_q;
    cvld_d  = cvld_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (signal_start) begin
          x_d   = ciphertext[2*WORD-1:WORD];
          y_d   = ciphertext[WORD-1:0];
          k_d   = key[2*WORD-1:WORD];
          l_d   = key[WORD-1:0];
          ctr_d = '0;
          if (cache_hit) begin
            ctr_d   = CTR_LAST;
            state_d = ST_DECRYPT;
          end else begin
            state_d = ST_EXPAND;
`ifdef SPECK_KEY_CACHE_EN
            // The key store is about to be overwritten, so drop the old entry.
            ckey_d  = key;
            cvld_d  = 1'b0;
`endif
          end
        end
      end
      ST_EXPAND: begin
        rk_we = 1'b1;
        l_d   = l_step;
        k_d   = k_step;
        if (ctr_q == CTR_LAST) begin
          state_d = ST_DECRYPT;
`ifdef SPECK_KEY_CACHE_EN
          cvld_d  = 1'b1;
`endif
        end else begin
          ctr_d = ctr_q + CTR_W'(1);
        end
      end
      ST_DECRYPT: begin
        x_d = x_inv;
        y_d = y_inv;
        if (ctr_q == '0) state_d = ST_DONE;
        else             ctr_d   = ctr_q - CTR_W'(1);
      end
      ST_DONE: begin
        pt_d    = {x_q, y_q};
        fin_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ctr_q   <= '0;
      pt_q    <= '0;
      fin_q   <= 1'b0;
`ifdef SPECK_KEY_CACHE_EN
      cvld_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      pt_q    <= pt_d;
      fin_q   <= fin_d;
`ifdef SPECK_KEY_CACHE_EN
      cvld_q  <= cvld_d;
`endif
    end
  end

  // Working words and the round-key store carry no reset.
  always_ff @(posedge clk) begin
    x_q <= x_d;
    y_q <= y_d;
    k_q <= k_d;
    l_q <= l_d;
`ifdef SPECK_KEY_CACHE_EN
    ckey_q <= ckey_d;
`endif
    if (rk_we) rk_q[ctr_q] <= k_q;
  end

  assign plaintext      = pt_q;
  assign finished       = fin_q;
  assign state_response = state_q;

endmodule

// File: tb/tb_speck_decrypt_core.sv
// Self-checking bench for speck_decrypt_core: directed steps plus random
// round trips against a behavioural SPECK128/128 encryption model.
module tb_speck_decrypt_core;

  localparam int NR    = 32;
  localparam int LAT_F = 2 * NR + 1;
  localparam int LAT_C = NR + 1;
`ifdef SPECK_KEY_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  localparam logic [127:0] OFF_KEY = {64'h0706050403020100, 64'h0f0e0d0c0b0a0908};
  localparam logic [127:0] OFF_CT  = {64'ha65d985179783265, 64'h7860fedf5c570d18};
  localparam logic [127:0] OFF_PT  = {64'h6c61766975716520, 64'h7469206564616d20};

  logic         clk = 1'b0;
  logic         rst;
  logic         signal_start;
  logic [127:0] key;
  logic [127:0] ciphertext;
  logic [127:0] plaintext;
  logic         finished;
  logic [3:0]   state_response;

  int errors = 0;
  int checks = 0;

  bit           m_vld = 1'b0;
  logic [127:0] m_key = '0;

  speck_decrypt_core dut (
    .clk            (clk),
    .rst            (rst),
    .signal_start   (signal_start),
    .key            (key),
    .ciphertext     (ciphertext),
    .plaintext      (plaintext),
    .finished       (finished),
    .state_response (state_response)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] m_ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  function automatic logic [63:0] m_rol(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic logic [127:0] speck_enc(input logic [127:0] key_in, input logic [127:0] pt);
    logic [63:0] kk, ll, xx, yy;
    logic [63:0] rks [NR];
    kk = key_in[127:64];
    ll = key_in[63:0];
    for (int i = 0; i < NR; i++) begin
      rks[i] = kk;
      ll = (kk + m_ror(ll, 8)) ^ 64'(i);
      kk = m_rol(kk, 3) ^ ll;
    end
    xx = pt[127:64];
    yy = pt[63:0];
    for (int i = 0; i < NR; i++) begin
      xx = (m_ror(xx, 8) + yy) ^ rks[i];
      yy = m_rol(yy, 3) ^ xx;
    end
    return {xx, yy};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic bit model_hit(input logic [127:0] k);
    return CACHE_EN && m_vld && (k == m_key);
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    check({tag, "_state"}, 128'(state_response), 128'(0));
    check({tag, "_fin"},   128'(finished),       128'(0));
    check({tag, "_pt"},    plaintext,            128'(0));
    rst   = 1'b0;
    m_vld = 1'b0;
  endtask

  // mode: 0 plain, 1 start pulses while busy, 2 inputs change after start, 3 reset mid-DECRYPT
  task automatic run_op(input logic [127:0] k, input logic [127:0] ct,
                        input logic [127:0] pt, input string tag, input int mode);
    bit hit;
    int lat_exp;
    int n;
    int extra;
    bit done;
    hit     = model_hit(k);
    lat_exp = hit ? LAT_C : LAT_F;
    key          = k;
    ciphertext   = ct;
    signal_start = 1'b1;
    @(posedge clk); #1;
    signal_start = 1'b0;
    n    = 0;
    done = 1'b0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) check({tag, "_st1"}, 128'(state_response), hit ? 128'(2) : 128'(1));
      if (mode == 1) signal_start = (n == 5) || (n == lat_exp - 10);
      if (mode == 2 && n == 1) begin
        key        = rnd128();
        ciphertext = rnd128();
      end
      if (mode == 3 && n == lat_exp - 25) begin
        do_reset({tag, "_abort"});
        return;
      end
      if (n == lat_exp - 1) check({tag, "_stdone"}, 128'(state_response), 128'(3));
      if (finished) done = 1'b1;
    end
    check({tag, "_lat"}, 128'(n), 128'(lat_exp));
    check({tag, "_pt"},  plaintext, pt);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 128'(finished), 128'(0));
    if (mode == 1) begin
      extra = 0;
      for (int i = 0; i < 80; i++) begin
        @(posedge clk); #1;
        if (finished) extra++;
      end
      check({tag, "_nodup"}, 128'(extra), 128'(0));
      check({tag, "_hold"},  plaintext, pt);
    end
    if (!hit) begin
      m_vld = 1'b1;
      m_key = k;
    end
  endtask

  task automatic wait_fin(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!finished && n < 200);
  endtask

  initial begin
    logic [127:0] k_a, k_b, p_a, c_a;
    int n1, lat1, lat2;
    bit h1;

    rst          = 1'b1;
    signal_start = 1'b0;
    key          = '0;
    ciphertext   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 128'(state_response), 128'(0));
    check("rst_fin",   128'(finished),       128'(0));
    check("rst_pt",    plaintext,            128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(OFF_KEY, OFF_CT, OFF_PT, "official", 0);
    run_op(OFF_KEY, OFF_CT, OFF_PT, "official_again", 0);

    k_a = rnd128();
    p_a = rnd128();
    run_op(k_a, speck_enc(k_a, p_a), p_a, "new_key", 0);
    do_reset("between");
    run_op(k_a, speck_enc(k_a, p_a), p_a, "after_rst", 0);

    k_b = rnd128();
    p_a = rnd128();
    run_op(k_b, speck_enc(k_b, p_a), p_a, "busy_start", 1);

    p_a = rnd128();
    run_op(k_b, speck_enc(k_b, p_a), p_a, "in_change", 2);

    // Start held high: second operation begins right after DONE.
    k_a = rnd128();
    p_a = rnd128();
    c_a = speck_enc(k_a, p_a);
    h1   = model_hit(k_a);
    lat1 = h1 ? LAT_C : LAT_F;
    key          = k_a;
    ciphertext   = c_a;
    signal_start = 1'b1;
    @(posedge clk); #1;
    wait_fin(n1);
    check("hold_lat1", 128'(n1), 128'(lat1));
    check("hold_pt1",  plaintext, p_a);
    if (!h1) begin
      m_vld = 1'b1;
      m_key = k_a;
    end
    lat2 = model_hit(k_a) ? LAT_C : LAT_F;
    wait_fin(n1);
    signal_start = 1'b0;
    check("hold_gap", 128'(n1), 128'(lat2 + 1));
    check("hold_pt2", plaintext, p_a);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("hold_idle", 128'(state_response), 128'(0));

    k_b = rnd128();
    p_a = rnd128();
    run_op(k_b, speck_enc(k_b, p_a), p_a, "rst_mid", 3);
    run_op(OFF_KEY, OFF_CT, OFF_PT, "post_abort", 0);

    for (int v = 0; v < 100; v++) begin
      k_a = ((v % 4) == 3) ? k_b : rnd128();
      p_a = rnd128();
      run_op(k_a, speck_enc(k_a, p_a), p_a, $sformatf("rt%0d", v), 0);
      k_b = k_a;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
